mem_access: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the execute stage's access op/size, effective address, store/merge data and destination register.
- Runs a registered, stall-able data-bus transaction and performs byte-lane steering, load extension, LWL/LWR merge and LL/SC link tracking.
- Produces write-back data and destination, plus address-error exceptions for the exception unit.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access.sv | 165 ++++++++++++++++
 tb/tb_mem_access.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access encodings, FSM states and alignment helper for the memory stage
package mem_access_pkg;

  localparam logic [1:0] ACCESS_OP_D2R = 2'd0;
  localparam logic [1:0] ACCESS_OP_M2R = 2'd1;
  localparam logic [1:0] ACCESS_OP_R2M = 2'd2;

  localparam logic [2:0] ACCESS_SZ_BYTE  = 3'd0;
  localparam logic [2:0] ACCESS_SZ_HALF  = 3'd1;
  localparam logic [2:0] ACCESS_SZ_WORD  = 3'd2;
  localparam logic [2:0] ACCESS_SZ_LEFT  = 3'd3;
  localparam logic [2:0] ACCESS_SZ_RIGHT = 3'd4;

  localparam logic [7:0] OP_LL = 8'h30;
  localparam logic [7:0] OP_SC = 8'h38;

  typedef enum logic [1:0] {
    MEMST_IDLE   = 2'd0,
    MEMST_ACCESS = 2'd1,
    MEMST_DONE   = 2'd2
  } memst_e;

  // LL/SC are always word accesses, whatever size the decoder supplies
  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a, input logic llsc);
    return ((sz == ACCESS_SZ_HALF) && a[0]) || (((sz == ACCESS_SZ_WORD) || llsc) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable and store steering, load lane select/extend and LWL/LWR merge
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  sz_i,
  input  logic        unsigned_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rddata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wrdata_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  sh;
  logic [4:0]  rsh;
  logic [31:0] rd_shr;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwl;
  logic [31:0] lwr;

  assign sh     = {addr_lo_i, 3'b000};
  assign rsh    = 5'd24 - sh;
  assign rd_shr = rddata_i >> sh;
  assign b      = rd_shr[7:0];
  assign h      = addr_lo_i[1] ? rddata_i[31:16] : rddata_i[15:0];
  assign lwl    = (rddata_i << rsh) | (rt_i & (32'h00FF_FFFF >> sh));
  assign lwr    = (rddata_i >> sh) | (rt_i & ~(32'hFFFF_FFFF >> sh));

  always_comb begin
    be_o      = 4'b1111;
    wrdata_o  = rt_i;
    ld_data_o = rddata_i;
    case (sz_i)
      ACCESS_SZ_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        wrdata_o  = {4{rt_i[7:0]}};
        ld_data_o = {{24{b[7] & ~unsigned_i}}, b};
      end
      ACCESS_SZ_HALF: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wrdata_o  = {2{rt_i[15:0]}};
        ld_data_o = {{16{h[15] & ~unsigned_i}}, h};
      end
      ACCESS_SZ_LEFT: begin
        be_o      = 4'b1111 >> (2'd3 - addr_lo_i);
        wrdata_o  = rt_i >> rsh;
        ld_data_o = lwl;
      end
      ACCESS_SZ_RIGHT: begin
        be_o      = 4'b1111 << addr_lo_i;
        wrdata_o  = rt_i << sh;
        ld_data_o = lwr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage with registered stall-able bus transaction, LL/SC link bit and address-error detection
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic        eret,
  input  logic [7:0]  op,
  input  logic        flag_unsigned,
  input  logic [1:0]  mem_access_op,
  input  logic [2:0]  mem_access_sz,
  input  logic [31:0] data_i,
  input  logic [31:0] mem_addr,
  input  logic [4:0]  reg_addr_i,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_wrdata,
  input  logic [31:0] bus_rddata,
  input  logic        bus_stall,
  output logic [31:0] data_o,
  output logic [4:0]  reg_addr_o,
  output logic        stall,
  output logic        addr_err_load,
  output logic        addr_err_store,
  output logic [31:0] badvaddr
);

  memst_e      state_q, state_d;
  logic        llbit_q, llbit_d;
  logic        drain_q, drain_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  be_q, be_d;
  logic        rds_q, rds_d;
  logic        wrs_q, wrs_d;
  logic [4:0]  dst_q, dst_d;
  logic        is_ll, is_sc, is_load, is_store, is_mem, mis, sc_fail, start, drop;
  logic [3:0]  be;
  logic [31:0] wrdata;
  logic [31:0] ld_data;

  mem_lane_align u_align (
    .addr_lo_i (mem_addr[1:0]),
    .sz_i      (mem_access_sz),
    .unsigned_i(flag_unsigned),
    .rt_i      (data_i),
    .rddata_i  (bus_rddata),
    .be_o      (be),
    .wrdata_o  (wrdata),
    .ld_data_o (ld_data)
  );

  assign is_ll    = op == OP_LL;
  assign is_sc    = op == OP_SC;
  assign is_load  = mem_access_op == ACCESS_OP_M2R;
  assign is_store = mem_access_op == ACCESS_OP_R2M;
  assign is_mem   = is_load | is_store;
  assign mis      = misaligned(mem_access_sz, mem_addr[1:0], is_ll | is_sc);
  assign sc_fail  = is_store & is_sc & ~llbit_q;
  assign start    = (state_q == MEMST_IDLE) & is_mem & ~mis & ~exception_flush;
  assign drop     = drain_q | exception_flush;

  assign bus_address     = addr_q;
  assign bus_byte_enable = be_q;
  assign bus_read        = rds_q;
  assign bus_write       = wrs_q;
  assign bus_wrdata      = wrdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MEMST_IDLE;
      llbit_q  <= 1'b0;
      drain_q  <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      res_q    <= '0;
      be_q     <= '0;
      rds_q    <= 1'b0;
      wrs_q    <= 1'b0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      llbit_q  <= llbit_d;
      drain_q  <= drain_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      res_q    <= res_d;
      be_q     <= be_d;
      rds_q    <= rds_d;
      wrs_q    <= wrs_d;
      dst_q    <= dst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    llbit_d  = llbit_q;
    drain_d  = drain_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    res_d    = res_q;
    be_d     = be_q;
    rds_d    = rds_q;
    wrs_d    = wrs_q;
    dst_d    = dst_q;
    case (state_q)
      MEMST_IDLE: if (start) begin
        // a failing SC never touches the bus and reports 0 straight from DONE
        state_d  = sc_fail ? MEMST_DONE : MEMST_ACCESS;
        addr_d   = {mem_addr[31:2], 2'b00};
        be_d     = be;
        wrdata_d = wrdata;
        rds_d    = is_load;
        wrs_d    = is_store & ~sc_fail;
        res_d    = 32'd0;
        dst_d    = reg_addr_i;
        drain_d  = 1'b0;
      end
      MEMST_ACCESS: begin
        drain_d = drop;
        if (!bus_stall) begin
          state_d = drop ? MEMST_IDLE : MEMST_DONE;
          rds_d   = 1'b0;
          wrs_d   = 1'b0;
          drain_d = 1'b0;
          res_d   = is_sc ? 32'd1 : ld_data;
          dst_d   = (is_load | is_sc) ? reg_addr_i : 5'd0;
          llbit_d = llbit_q | (is_ll & is_load & ~drop);
        end
      end
      MEMST_DONE: state_d = MEMST_IDLE;
      default:    state_d = MEMST_IDLE;
    endcase
    if (eret | exception_flush) llbit_d = 1'b0;
  end

  always_comb begin
    data_o         = data_i;
    reg_addr_o     = 5'd0;
    stall          = 1'b0;
    addr_err_load  = 1'b0;
    addr_err_store = 1'b0;
    badvaddr       = 32'd0;
    case (state_q)
      MEMST_IDLE: begin
        stall          = start;
        reg_addr_o     = (is_mem | exception_flush) ? 5'd0 : reg_addr_i;
        addr_err_load  = is_load & mis;
        addr_err_store = is_store & mis;
        badvaddr       = (is_mem & mis) ? mem_addr : 32'd0;
      end
      MEMST_ACCESS: stall = 1'b1;
      MEMST_DONE: begin
        data_o     = res_q;
        reg_addr_o = exception_flush ? 5'd0 : dst_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven scoreboard bench for the mem_access memory stage
module tb_mem_access;
  import mem_access_pkg::*;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  aop;
    logic [2:0]  sz;
    logic        uns;
    logic [31:0] addr, din, rdata;
    logic [4:0]  rd;
    int          nstall, flush_cyc;
    logic [1:0]  rw, err;
    logic [3:0]  be;
    logic [31:0] wdata, dout;
    logic [4:0]  rego;
    logic        chkd;
    int          stalls;
  } vec_t;

  logic        clk = 0, rst = 1, exception_flush = 0, eret = 0;
  logic [7:0]  op = 0;
  logic        flag_unsigned = 0;
  logic [1:0]  mem_access_op = ACCESS_OP_D2R;
  logic [2:0]  mem_access_sz = ACCESS_SZ_BYTE;
  logic [31:0] data_i = 0, mem_addr = 0, bus_rddata = 0;
  logic [4:0]  reg_addr_i = 0;
  logic        bus_stall = 0;
  logic [31:0] bus_address, bus_wrdata, data_o, badvaddr;
  logic [3:0]  bus_byte_enable;
  logic        bus_read, bus_write, stall, addr_err_load, addr_err_store;
  logic [4:0]  reg_addr_o;

  int checks = 0, errors = 0;
  string cur = "reset";
  vec_t tbl[$];
  vec_t sb[$];

  mem_access dut (
    .clk(clk), .rst(rst), .exception_flush(exception_flush), .eret(eret), .op(op),
    .flag_unsigned(flag_unsigned), .mem_access_op(mem_access_op), .mem_access_sz(mem_access_sz),
    .data_i(data_i), .mem_addr(mem_addr), .reg_addr_i(reg_addr_i), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_read(bus_read), .bus_write(bus_write),
    .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata), .bus_stall(bus_stall), .data_o(data_o),
    .reg_addr_o(reg_addr_o), .stall(stall), .addr_err_load(addr_err_load),
    .addr_err_store(addr_err_store), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [7:0] o, input logic [1:0] aop, input logic [2:0] sz,
      input logic uns, input logic [31:0] addr, input logic [31:0] din, input logic [31:0] rdata,
      input logic [4:0] rd, input int nstall, input int flush_cyc, input logic [1:0] rw,
      input logic [1:0] err, input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] dout,
      input logic [4:0] rego, input logic chkd, input int stalls);
    vec_t v;
    v.op = o; v.aop = aop; v.sz = sz; v.uns = uns; v.addr = addr; v.din = din; v.rdata = rdata;
    v.rd = rd; v.nstall = nstall; v.flush_cyc = flush_cyc; v.rw = rw; v.err = err; v.be = be;
    v.wdata = wdata; v.dout = dout; v.rego = rego; v.chkd = chkd; v.stalls = stalls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur, name, act, exp);
    end
  endtask

  task automatic bubble();
    op = 8'h00; mem_access_op = ACCESS_OP_D2R; mem_access_sz = ACCESS_SZ_BYTE;
    data_i = 0; reg_addr_i = 0; mem_addr = 0; flag_unsigned = 0;
  endtask

  task automatic apply(input vec_t v);
    op = v.op; mem_access_op = v.aop; mem_access_sz = v.sz; flag_unsigned = v.uns;
    mem_addr = v.addr; data_i = v.din; bus_rddata = v.rdata; reg_addr_i = v.rd;
    bus_stall = v.nstall != 0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int stalls = 0, rdc = 0, wrc = 0, left = v.nstall;
    bit fin = 0;
    @(posedge clk); #1;
    apply(v);
    sb.push_back(v);
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      rdc += int'(bus_read);
      wrc += int'(bus_write);
      if (!stall) fin = 1;
      else begin
        stalls++;
        if (cyc == 1) begin
          chk("bus_address", bus_address, v.addr & 32'hFFFF_FFFC);
          chk("byte_enable", {28'd0, bus_byte_enable}, {28'd0, v.be});
          if (v.rw[1]) chk("bus_wrdata", bus_wrdata, v.wdata);
        end
        @(posedge clk); #1;
        if (cyc >= 1) begin
          if (left == 0 && v.flush_cyc != 0) bubble();
          left--;
          bus_stall = left > 0;
        end
        exception_flush = (cyc + 1 == v.flush_cyc);
      end
    end
    exception_flush = 0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s/timeout: stall still high after 40 cycles, expected release", cur);
    end
    e = sb.pop_front();
    chk("stall_cycles", stalls, e.stalls);
    chk("read_cycles", rdc, e.rw[0] ? e.nstall + 1 : 0);
    chk("write_cycles", wrc, e.rw[1] ? e.nstall + 1 : 0);
    if (e.chkd) chk("data_o", data_o, e.dout);
    chk("reg_addr_o", {27'd0, reg_addr_o}, {27'd0, e.rego});
    chk("addr_err_load", {31'd0, addr_err_load}, {31'd0, e.err[0]});
    chk("addr_err_store", {31'd0, addr_err_store}, {31'd0, e.err[1]});
    chk("badvaddr", badvaddr, (e.err != 0) ? e.addr : 32'd0);
  endtask

  initial begin
    vec_t ll, sc_ok, sc_fail, ll_flush;
    ll       = mk(OP_LL, ACCESS_OP_M2R, ACCESS_SZ_WORD, 0, 32'h5000, 0, 32'h77, 5'd14, 0, 0, 2'b01, 2'b00, 4'b1111, 0, 32'h77, 5'd14, 1, 2);
    sc_ok    = mk(OP_SC, ACCESS_OP_R2M, ACCESS_SZ_WORD, 0, 32'h5000, 32'h99, 0, 5'd15, 0, 0, 2'b10, 2'b00, 4'b1111, 32'h99, 32'd1, 5'd15, 1, 2);
    sc_fail  = mk(OP_SC, ACCESS_OP_R2M, ACCESS_SZ_WORD, 0, 32'h5000, 32'h99, 0, 5'd15, 0, 0, 2'b00, 2'b00, 4'b1111, 0, 32'd0, 5'd15, 1, 1);
    ll_flush = mk(OP_LL, ACCESS_OP_M2R, ACCESS_SZ_WORD, 0, 32'h6000, 0, 32'hABCD, 5'd16, 2, 1, 2'b01, 2'b00, 4'b1111, 0, 32'd0, 5'd0, 1, 4);

    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_BYTE, 0, 32'h1003, 0, 32'h80AABBCC, 5'd5, 0, 0, 2'b01, 2'b00, 4'b1000, 0, 32'hFFFFFF80, 5'd5, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_BYTE, 1, 32'h1002, 0, 32'h80AABBCC, 5'd6, 0, 0, 2'b01, 2'b00, 4'b0100, 0, 32'h000000AA, 5'd6, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_HALF, 0, 32'h1002, 0, 32'h80AABBCC, 5'd7, 0, 0, 2'b01, 2'b00, 4'b1100, 0, 32'hFFFF80AA, 5'd7, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_HALF, 1, 32'h1000, 0, 32'h80AABBCC, 5'd8, 0, 0, 2'b01, 2'b00, 4'b0011, 0, 32'h0000BBCC, 5'd8, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_WORD, 0, 32'h1004, 0, 32'h12345678, 5'd9, 1, 0, 2'b01, 2'b00, 4'b1111, 0, 32'h12345678, 5'd9, 1, 3));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_LEFT, 0, 32'h4001, 32'hDEADBEEF, 32'h01020304, 5'd10, 0, 0, 2'b01, 2'b00, 4'b0011, 0, 32'h0304BEEF, 5'd10, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_LEFT, 0, 32'h4003, 32'hDEADBEEF, 32'h01020304, 5'd10, 0, 0, 2'b01, 2'b00, 4'b1111, 0, 32'h01020304, 5'd10, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_RIGHT, 0, 32'h4002, 32'hDEADBEEF, 32'h01020304, 5'd11, 0, 0, 2'b01, 2'b00, 4'b1100, 0, 32'hDEAD0102, 5'd11, 1, 2));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_RIGHT, 0, 32'h2001, 32'h11223344, 0, 5'd12, 3, 0, 2'b10, 2'b00, 4'b1110, 32'h22334400, 0, 5'd0, 0, 5));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_BYTE, 0, 32'h2002, 32'h000000A5, 0, 5'd12, 0, 0, 2'b10, 2'b00, 4'b0100, 32'hA5A5A5A5, 0, 5'd0, 0, 2));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_HALF, 0, 32'h2002, 32'h0000BEEF, 0, 5'd12, 0, 0, 2'b10, 2'b00, 4'b1100, 32'hBEEFBEEF, 0, 5'd0, 0, 2));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_LEFT, 0, 32'h2001, 32'h11223344, 0, 5'd12, 0, 0, 2'b10, 2'b00, 4'b0011, 32'h00001122, 0, 5'd0, 0, 2));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_WORD, 0, 32'h2000, 32'hCAFEF00D, 0, 5'd12, 1, 0, 2'b10, 2'b00, 4'b1111, 32'hCAFEF00D, 0, 5'd0, 0, 3));
    tbl.push_back(mk(0, ACCESS_OP_M2R, ACCESS_SZ_WORD, 0, 32'h3002, 0, 32'h11111111, 5'd13, 0, 0, 2'b00, 2'b01, 4'b0000, 0, 0, 5'd0, 0, 0));
    tbl.push_back(mk(0, ACCESS_OP_R2M, ACCESS_SZ_HALF, 0, 32'h3001, 32'h1234, 0, 5'd13, 0, 0, 2'b00, 2'b10, 4'b0000, 0, 0, 5'd0, 0, 0));
    tbl.push_back(mk(0, ACCESS_OP_D2R, ACCESS_SZ_WORD, 0, 32'h0, 32'h55, 0, 5'd7, 0, 0, 2'b00, 2'b00, 4'b0000, 0, 32'h55, 5'd7, 1, 0));
    tbl.push_back(ll);
    tbl.push_back(sc_ok);
    tbl.push_back(mk(OP_SC, ACCESS_OP_R2M, ACCESS_SZ_WORD, 0, 32'h5002, 32'h99, 0, 5'd15, 0, 0, 2'b00, 2'b10, 4'b0000, 0, 0, 5'd0, 0, 0));

    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_read", {31'd0, bus_read}, 32'd0);
    chk("rst_write", {31'd0, bus_write}, 32'd0);
    chk("rst_be", {28'd0, bus_byte_enable}, 32'd0);
    chk("rst_address", bus_address, 32'd0);
    chk("rst_reg_addr_o", {27'd0, reg_addr_o}, 32'd0);
    @(posedge clk); #1 rst = 0;

    foreach (tbl[i]) begin
      cur = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    cur = "ll_eret_sc";
    run_vec(ll);
    @(posedge clk); #1 bubble(); eret = 1;
    @(posedge clk); #1 eret = 0;
    run_vec(sc_fail);

    cur = "ll_flush_sc";
    run_vec(ll);
    run_vec(ll_flush);
    run_vec(sc_fail);

    cur = "rst_mid_access";
    run_vec(ll);
    @(posedge clk); #1;
    apply(mk(0, ACCESS_OP_M2R, ACCESS_SZ_WORD, 0, 32'h7000, 0, 0, 5'd3, 1, 0, 2'b01, 2'b00, 4'b1111, 0, 0, 5'd3, 1, 2));
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_read", {31'd0, bus_read}, 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_read_drop", {31'd0, bus_read}, 32'd0);
    chk("rst_addr_clear", bus_address, 32'd0);
    @(posedge clk); #1 rst = 0; bubble(); bus_stall = 0;
    run_vec(sc_fail);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
